// File: rtl/mll_pkg.sv
// Shared types for the multi-list linked-list node pool: op codes, FSM states and the node record.
// Node record widths come from the MLL_* constants, so pool sizing is changed here.
package mll_pkg;

    localparam int MLL_DATA_WIDTH = 8;
    localparam int MLL_MAX_NODE   = 8;
    localparam int MLL_NUM_LISTS  = 4;
    localparam int MLL_ADDR_WIDTH = $clog2(MLL_MAX_NODE + 1);

    typedef enum logic [2:0] {
        OP_READ         = 3'd0,
        OP_PUSH_FRONT   = 3'd1,
        OP_PUSH_BACK    = 3'd2,
        OP_POP_FRONT    = 3'd3,
        OP_DELETE_VALUE = 3'd4
    } mll_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WALK,
        ST_UNLINK,
        ST_DONE
    } mll_state_e;

    typedef struct packed {
        logic [MLL_DATA_WIDTH-1:0] data;
        logic [MLL_ADDR_WIDTH-1:0] next;
    } node_t;

    function automatic logic op_is_push(input logic [2:0] op);
        return (op == OP_PUSH_FRONT) || (op == OP_PUSH_BACK);
    endfunction

endpackage

// File: rtl/mll_free_alloc.sv
// Free-node finder for the shared pool: lowest-index clear bit of the valid map,
// plus pool full/empty flags. alloc_addr is the NULL address (MAX_NODE) when the pool is full.
module mll_free_alloc
    import mll_pkg::*;
#(
    parameter int MAX_NODE   = MLL_MAX_NODE,
    parameter int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic [MAX_NODE-1:0]   valid,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  full,
    output logic                  empty
);

    // One-hot marker of the lowest free node: free here and every lower node in use.
    logic [MAX_NODE-1:0] first_free;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_NODE; gi++) begin : g_first_free
            if (gi == 0) begin : g_lsb
                assign first_free[gi] = ~valid[0];
            end else begin : g_upper
                assign first_free[gi] = ~valid[gi] & (&valid[gi-1:0]);
            end
        end
    endgenerate

    assign full  = &valid;
    assign empty = ~|valid;

    always_comb begin
        alloc_addr = '0;
        for (int i = 0; i < MAX_NODE; i++) begin
            if (first_free[i]) begin
                alloc_addr = alloc_addr | ADDR_WIDTH'(i);
            end
        end
        if (full) begin
            alloc_addr = ADDR_WIDTH'(MAX_NODE);
        end
    end

endmodule

// File: rtl/multi_list_linked_list.sv
// NUM_LISTS singly linked lists sharing one MAX_NODE pool: READ, PUSH_FRONT/BACK, POP_FRONT, DELETE_VALUE.
// Define MLL_LEN_OUT_EN to add per-list length counters, the list_len port and early READ range faults.
module multi_list_linked_list
    import mll_pkg::*;
#(
    parameter int DATA_WIDTH  = MLL_DATA_WIDTH,
    parameter int MAX_NODE    = MLL_MAX_NODE,
    parameter int NUM_LISTS   = MLL_NUM_LISTS,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1),
    localparam int LIST_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_start,
    input  logic [2:0]            op,
    input  logic [LIST_WIDTH-1:0] list_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] pos_in,
    output logic                  op_ready,
    output logic                  op_done,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  full,
    output logic                  empty
`ifdef MLL_LEN_OUT_EN
    ,
    output logic [ADDR_WIDTH-1:0] list_len
`endif
);

    localparam int IDX_WIDTH = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
    localparam logic [ADDR_WIDTH-1:0] NULL_ADDR = ADDR_WIDTH'(MAX_NODE);

    mll_state_e state_reg, state_next;

    logic [2:0]            op_reg;
    logic [LIST_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0] din_reg;
    logic [ADDR_WIDTH-1:0] pos_reg;
    logic [ADDR_WIDTH-1:0] cur_reg, prev_reg, cnt_reg;
    logic [ADDR_WIDTH-1:0] head_reg [NUM_LISTS];
    logic [ADDR_WIDTH-1:0] tail_reg [NUM_LISTS];
    logic [MAX_NODE-1:0]   valid_reg;
    node_t                 node_mem [MAX_NODE];

    logic                  fault_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic [ADDR_WIDTH-1:0] addr_out_reg;

    logic [ADDR_WIDTH-1:0] alloc_addr;
    logic [IDX_WIDTH-1:0]  alloc_idx;
    logic                  full_w, empty_w;

    mll_free_alloc #(
        .MAX_NODE   (MAX_NODE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_alloc (
        .valid      (valid_reg),
        .alloc_addr (alloc_addr),
        .full       (full_w),
        .empty      (empty_w)
    );

    assign alloc_idx = alloc_addr[IDX_WIDTH-1:0];

    // Out-of-range list select only exists when NUM_LISTS is not a power of two.
    logic sel_bad;
    generate
        if ((1 << LIST_WIDTH) == NUM_LISTS) begin : g_sel_full
            assign sel_bad = 1'b0;
        end else begin : g_sel_chk
            assign sel_bad = (int'(list_sel) >= NUM_LISTS);
        end
    endgenerate

    logic [LIST_WIDTH-1:0] sel_safe;
    logic [ADDR_WIDTH-1:0] head_live;
    logic                  is_push, needs_node, op_illegal, len_fault, start_fault;

    assign sel_safe   = sel_bad ? '0 : list_sel;
    assign head_live  = head_reg[sel_safe];
    assign op_illegal = (op > OP_DELETE_VALUE);
    assign is_push    = op_is_push(op);
    assign needs_node = (op == OP_READ) || (op == OP_POP_FRONT) || (op == OP_DELETE_VALUE);

`ifdef MLL_LEN_OUT_EN
    logic [ADDR_WIDTH-1:0] len_reg [NUM_LISTS];

    assign list_len  = len_reg[sel_safe];
    assign len_fault = (op == OP_READ) && (pos_in >= len_reg[sel_safe]);
`else
    assign len_fault = 1'b0;
`endif

    assign start_fault = op_illegal || sel_bad || (is_push && full_w) ||
                         (needs_node && (head_live == NULL_ADDR)) || len_fault;

    logic [ADDR_WIDTH-1:0] head_sel, tail_sel;
    node_t                 cur_node, head_node;
    logic                  walk_fault;

    assign head_sel  = head_reg[sel_reg];
    assign tail_sel  = tail_reg[sel_reg];
    assign cur_node  = node_mem[cur_reg[IDX_WIDTH-1:0]];
    assign head_node = node_mem[head_sel[IDX_WIDTH-1:0]];

    always_comb begin
        state_next = state_reg;
        walk_fault = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (op_start) begin
                    if (start_fault) begin
                        state_next = ST_DONE;
                    end else if (is_push || (op == OP_POP_FRONT)) begin
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_WALK;
                    end
                end
            end
            ST_EXEC:   state_next = ST_DONE;
            ST_WALK: begin
                if (op_reg == OP_READ) begin
                    if (cnt_reg == pos_reg) begin
                        state_next = ST_DONE;
                    end else if (cur_node.next == NULL_ADDR) begin
                        state_next = ST_DONE;
                        walk_fault = 1'b1;
                    end
                end else begin
                    if (cur_node.data == din_reg) begin
                        state_next = ST_UNLINK;
                    end else if (cur_node.next == NULL_ADDR) begin
                        state_next = ST_DONE;
                        walk_fault = 1'b1;
                    end
                end
            end
            ST_UNLINK: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            valid_reg <= '0;
            for (int i = 0; i < NUM_LISTS; i++) begin
                head_reg[i] <= NULL_ADDR;
                tail_reg[i] <= NULL_ADDR;
            end
            op_reg       <= '0;
            sel_reg      <= '0;
            din_reg      <= '0;
            pos_reg      <= '0;
            cur_reg      <= NULL_ADDR;
            prev_reg     <= NULL_ADDR;
            cnt_reg      <= '0;
            fault_reg    <= 1'b0;
            data_out_reg <= '0;
            addr_out_reg <= NULL_ADDR;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (op_start) begin
                        op_reg   <= op;
                        sel_reg  <= sel_safe;
                        din_reg  <= data_in;
                        pos_reg  <= pos_in;
                        cur_reg  <= head_live;
                        prev_reg <= NULL_ADDR;
                        cnt_reg  <= '0;
                        if (start_fault) begin
                            fault_reg    <= 1'b1;
                            addr_out_reg <= NULL_ADDR;
                        end
                    end
                end
                ST_EXEC: begin
                    fault_reg <= 1'b0;
                    if (op_reg == OP_POP_FRONT) begin
                        valid_reg[head_sel[IDX_WIDTH-1:0]] <= 1'b0;
                        data_out_reg      <= head_node.data;
                        addr_out_reg      <= head_sel;
                        head_reg[sel_reg] <= head_node.next;
                        if (head_sel == tail_sel) begin
                            tail_reg[sel_reg] <= NULL_ADDR;
                        end
                    end else begin
                        valid_reg[alloc_idx] <= 1'b1;
                        addr_out_reg         <= alloc_addr;
                        if (head_sel == NULL_ADDR) begin
                            head_reg[sel_reg] <= alloc_addr;
                            tail_reg[sel_reg] <= alloc_addr;
                        end else if (op_reg == OP_PUSH_FRONT) begin
                            head_reg[sel_reg] <= alloc_addr;
                        end else begin
                            tail_reg[sel_reg] <= alloc_addr;
                        end
                    end
                end
                ST_WALK: begin
                    if (state_next == ST_DONE) begin
                        fault_reg <= walk_fault;
                        if (walk_fault) begin
                            addr_out_reg <= NULL_ADDR;
                        end else begin
                            data_out_reg <= cur_node.data;
                            addr_out_reg <= cur_reg;
                        end
                    end else if (state_next == ST_WALK) begin
                        prev_reg <= cur_reg;
                        cur_reg  <= cur_node.next;
                        cnt_reg  <= cnt_reg + ADDR_WIDTH'(1);
                    end
                end
                ST_UNLINK: begin
                    fault_reg    <= 1'b0;
                    data_out_reg <= cur_node.data;
                    addr_out_reg <= cur_reg;
                    valid_reg[cur_reg[IDX_WIDTH-1:0]] <= 1'b0;
                    if (prev_reg == NULL_ADDR) begin
                        head_reg[sel_reg] <= cur_node.next;
                    end
                    if (cur_reg == tail_sel) begin
                        tail_reg[sel_reg] <= prev_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Node storage carries no reset; only nodes marked valid are ever read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state_reg == ST_EXEC) && (op_reg != OP_POP_FRONT)) begin
                node_mem[alloc_idx] <= '{data: din_reg,
                                         next: (op_reg == OP_PUSH_FRONT) ? head_sel : NULL_ADDR};
                if ((op_reg == OP_PUSH_BACK) && (tail_sel != NULL_ADDR)) begin
                    node_mem[tail_sel[IDX_WIDTH-1:0]].next <= alloc_addr;
                end
            end
            if ((state_reg == ST_UNLINK) && (prev_reg != NULL_ADDR)) begin
                node_mem[prev_reg[IDX_WIDTH-1:0]].next <= cur_node.next;
            end
        end
    end

`ifdef MLL_LEN_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LISTS; i++) begin
                len_reg[i] <= '0;
            end
        end else if (state_reg == ST_EXEC) begin
            if (op_reg == OP_POP_FRONT) begin
                len_reg[sel_reg] <= len_reg[sel_reg] - ADDR_WIDTH'(1);
            end else begin
                len_reg[sel_reg] <= len_reg[sel_reg] + ADDR_WIDTH'(1);
            end
        end else if (state_reg == ST_UNLINK) begin
            len_reg[sel_reg] <= len_reg[sel_reg] - ADDR_WIDTH'(1);
        end
    end
`endif

    assign op_ready = (state_reg == ST_IDLE);
    assign op_done  = (state_reg == ST_DONE);
    assign fault    = fault_reg;
    assign data_out = data_out_reg;
    assign addr_out = addr_out_reg;
    assign full     = full_w;
    assign empty    = empty_w;

endmodule

// File: tb/tb_multi_list_linked_list.sv
// Scoreboard bench for multi_list_linked_list: a queue-based list model predicts every completion.
module tb_multi_list_linked_list;

    localparam int DW = 8;
    localparam int MN = 8;
    localparam int NL = 4;
    localparam int AW = 4;
    localparam int LW = 2;
    localparam logic [AW-1:0] NULLA = 4'd8;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_start;
    logic [2:0]    op;
    logic [LW-1:0] list_sel;
    logic [DW-1:0] data_in;
    logic [AW-1:0] pos_in;
    logic          op_ready, op_done, fault, full, empty;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_out;
`ifdef MLL_LEN_OUT_EN
    logic [AW-1:0] list_len;
`endif

    always #5 clk = ~clk;

    multi_list_linked_list dut (
        .clk      (clk),
        .rst      (rst),
        .op_start (op_start),
        .op       (op),
        .list_sel (list_sel),
        .data_in  (data_in),
        .pos_in   (pos_in),
        .op_ready (op_ready),
        .op_done  (op_done),
        .fault    (fault),
        .data_out (data_out),
        .addr_out (addr_out),
        .full     (full),
        .empty    (empty)
`ifdef MLL_LEN_OUT_EN
        ,
        .list_len (list_len)
`endif
    );

    typedef struct {
        logic          fault;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        int            lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          lq[NL][$];
    logic [7:0]  mdata[MN];
    bit          mvalid[MN];
    logic [7:0]  held_data;
    int          op_num = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) lq[i].delete();
        for (int i = 0; i < MN; i++) mvalid[i] = 1'b0;
        held_data = '0;
    endtask

    function automatic int model_used();
        int u = 0;
        for (int i = 0; i < MN; i++) if (mvalid[i]) u++;
        return u;
    endfunction

    task automatic model_op(input logic [2:0] o, input int s, input logic [7:0] d, input int p);
        exp_t e;
        int   a = -1;
        int   k = -1;
        e.fault = 1'b1;
        e.addr  = NULLA;
        e.lat   = 1;
        e.data  = held_data;
        case (o)
            3'd1, 3'd2: begin
                if (model_used() < MN) begin
                    for (int i = MN - 1; i >= 0; i--) if (!mvalid[i]) a = i;
                    mvalid[a] = 1'b1;
                    mdata[a]  = d;
                    if (o == 3'd1) lq[s].push_front(a);
                    else           lq[s].push_back(a);
                    e.fault = 1'b0;
                    e.addr  = AW'(a);
                    e.lat   = 2;
                end
            end
            3'd3: begin
                if (lq[s].size() > 0) begin
                    a = lq[s].pop_front();
                    mvalid[a] = 1'b0;
                    held_data = mdata[a];
                    e.fault = 1'b0;
                    e.data  = mdata[a];
                    e.addr  = AW'(a);
                    e.lat   = 2;
                end
            end
            3'd0: begin
                if (lq[s].size() > 0) begin
                    if (p < lq[s].size()) begin
                        a = lq[s][p];
                        held_data = mdata[a];
                        e.fault = 1'b0;
                        e.data  = mdata[a];
                        e.addr  = AW'(a);
                        e.lat   = p + 2;
                    end else begin
`ifndef MLL_LEN_OUT_EN
                        e.lat = lq[s].size() + 1;
`endif
                    end
                end
            end
            3'd4: begin
                if (lq[s].size() > 0) begin
                    for (int i = 0; i < lq[s].size(); i++)
                        if (k < 0 && mdata[lq[s][i]] == d) k = i;
                    if (k >= 0) begin
                        a = lq[s][k];
                        lq[s].delete(k);
                        mvalid[a] = 1'b0;
                        held_data = mdata[a];
                        e.fault = 1'b0;
                        e.data  = mdata[a];
                        e.addr  = AW'(a);
                        e.lat   = k + 3;
                    end else begin
                        e.lat = lq[s].size() + 1;
                    end
                end
            end
            default: ;
        endcase
        exp_q.push_back(e);
    endtask

    task automatic do_op(input logic [2:0] o, input int s, input logic [7:0] d, input int p, input bit poke);
        exp_t  e;
        int    n;
        bit    seen;
        string t;
        op_num++;
        t = $sformatf("op%0d", op_num);
        @(negedge clk);
        model_op(o, s, d, p);
        check({t, "_ready"}, op_ready, 1);
        op       = o;
        list_sel = s[LW-1:0];
        data_in  = d;
        pos_in   = p[AW-1:0];
        op_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance; optionally keep hammering op_start while busy.
        op_start = poke;
        op       = 3'($urandom_range(1, 2));
        list_sel = LW'($urandom);
        data_in  = DW'($urandom);
        pos_in   = AW'($urandom);
        n    = 1;
        seen = 1'b0;
        while (n <= 40) begin
            if (op_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        op_start = 1'b0;
        e = exp_q.pop_front();
        check({t, "_done"}, seen, 1);
        if (seen) begin
            check({t, "_lat"},   n,        e.lat);
            check({t, "_fault"}, fault,    e.fault);
            check({t, "_addr"},  addr_out, e.addr);
            check({t, "_data"},  data_out, e.data);
        end
        $display("txn %0d op=%0d list=%0d din=%02h pos=%0d -> lat=%0d fault=%b addr=%0d data=%02h",
                 op_num, o, s, d, p, n, fault, addr_out, data_out);
        @(negedge clk);
        check({t, "_pulse"}, op_done, 0);
        check({t, "_idle"},  op_ready, 1);
        check({t, "_full"},  full,  (model_used() == MN));
        check({t, "_empty"}, empty, (model_used() == 0));
`ifdef MLL_LEN_OUT_EN
        for (int i = 0; i < NL; i++) begin
            list_sel = LW'(i);
            #1;
            check($sformatf("%s_len%0d", t, i), list_len, lq[i].size());
        end
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s6;
        bit  done_seen;
        rst      = 1'b1;
        op_start = 1'b0;
        op       = '0;
        list_sel = '0;
        data_in  = '0;
        pos_in   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_op_done",  op_done,  0);
        check("rst_fault",    fault,    0);
        check("rst_data_out", data_out, 0);
        check("rst_addr_out", addr_out, NULLA);
        check("rst_full",     full,     0);
        check("rst_empty",    empty,    1);
        check("rst_ready",    op_ready, 1);

        // Basic push-back and positional read
        do_op(3'd2, 0, 8'h11, 0, 0);
        do_op(3'd2, 0, 8'h22, 0, 0);
        do_op(3'd2, 0, 8'h33, 0, 0);
        do_op(3'd0, 0, 8'h00, 2, 0);
        // Push-front, pop, node reuse
        do_op(3'd1, 1, 8'hA0, 0, 0);
        do_op(3'd3, 1, 8'h00, 0, 0);
        do_op(3'd2, 2, 8'h55, 0, 0);
        // Delete mid-list, read after, delete miss
        do_op(3'd4, 0, 8'h22, 0, 0);
        do_op(3'd0, 0, 8'h00, 1, 0);
        do_op(3'd4, 0, 8'h99, 0, 0);
        // Fill the pool, then overflow
        do_op(3'd2, 1, 8'h61, 0, 0);
        do_op(3'd2, 3, 8'h62, 0, 0);
        do_op(3'd2, 1, 8'h63, 0, 0);
        do_op(3'd2, 3, 8'h64, 0, 0);
        do_op(3'd1, 0, 8'h65, 0, 0);
        do_op(3'd2, 2, 8'h77, 0, 0);
        // Empty-list pop, out-of-range read, illegal ops
        do_op(3'd3, 3, 8'h00, 0, 0);
        do_op(3'd3, 3, 8'h00, 0, 0);
        do_op(3'd3, 3, 8'h00, 0, 0);
        do_op(3'd0, 0, 8'h00, 5, 0);
        do_op(3'd6, 0, 8'h00, 0, 0);
        do_op(3'd7, 2, 8'h00, 0, 0);
        // Tail delete then append, head delete, busy op_start ignored
        do_op(3'd4, 1, 8'h63, 0, 0);
        do_op(3'd2, 1, 8'h70, 0, 0);
        do_op(3'd0, 1, 8'h00, 1, 1);
        do_op(3'd4, 0, 8'h65, 0, 0);
        do_op(3'd0, 0, 8'h00, 0, 0);
        do_op(3'd1, 2, 8'h88, 0, 0);
        do_op(3'd4, 2, 8'h55, 0, 0);
        do_op(3'd2, 2, 8'h99, 0, 0);
        do_op(3'd0, 2, 8'h00, 1, 1);

        // Reset during a walk discards the op and clears the pool
        s6 = 0;
        for (int i = 0; i < NL; i++) if (lq[i].size() > lq[s6].size()) s6 = i;
        @(negedge clk);
        op       = 3'd0;
        list_sel = s6[LW-1:0];
        pos_in   = AW'(lq[s6].size() - 1);
        op_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start  = 1'b0;
        rst       = 1'b1;
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (op_done) done_seen = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (op_done) done_seen = 1'b1;
        end
        model_reset();
        check("walk_rst_no_done", done_seen, 0);
        check("walk_rst_empty",   empty,     1);
        check("walk_rst_full",    full,      0);
        check("walk_rst_ready",   op_ready,  1);
        check("walk_rst_addr",    addr_out,  NULLA);
        $display("txn reset-during-walk list=%0d done_seen=%0b empty=%0b", s6, done_seen, empty);
        do_op(3'd2, 3, 8'h5A, 0, 0);

        // Random mix against the model
        for (int r = 0; r < 40; r++) begin
            int ro;
            ro = $urandom_range(0, 9);
            if (ro > 7) ro = 2;
            do_op(3'(ro), $urandom_range(0, NL - 1), 8'h40 | 8'($urandom_range(0, 7)),
                  $urandom_range(0, 9), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
